// File: rtl/prefetch_issue_arbiter.sv
// prefetch_issue_arbiter
//   Buffers best-offset prefetch requests in a small FIFO, drops duplicates
//   and stale entries, throttles prefetch issue on MSHR occupancy and
//   arbitrates the single lower-level request port with strict demand priority.
// Ports
//   clk, rst           clock, synchronous active-low reset
//   dm_*               demand-miss request in (valid/address) and ready out
//   pf_*               prefetch request pulse in, advisory not-full out
//   flush_i            discard every queued prefetch
//   mshr_occupancy_i   lower-level MSHRs currently in use
//   lo_*               registered request to the lower level (valid/ready)
//   drop_count_o       saturating count of dropped prefetches
module prefetch_issue_arbiter #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned LOGLINE        = 6,
  parameter int unsigned QDEPTH         = 8,
  parameter int unsigned MSHR_COUNT     = 16,
  parameter int unsigned MSHR_THRESHOLD = 12,
  parameter int unsigned MAX_AGE        = 63
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              dm_valid_i,
  input  logic [WIDTH-1:0]                  dm_address_i,
  output logic                              dm_ready_o,
  input  logic                              pf_valid_i,
  input  logic [WIDTH-1:0]                  pf_address_i,
  output logic                              pf_ready_o,
  input  logic                              flush_i,
  input  logic [$clog2(MSHR_COUNT+1)-1:0]   mshr_occupancy_i,
  output logic                              lo_valid_o,
  output logic [WIDTH-1:0]                  lo_address_o,
  output logic                              lo_is_prefetch_o,
  input  logic                              lo_ready_i,
  output logic [15:0]                       drop_count_o
);

  localparam int unsigned IDX_W  = $clog2(QDEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned AGE_W  = $clog2(MAX_AGE + 1);
  localparam int unsigned MSHR_W = $clog2(MSHR_COUNT + 1);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LINE_W = WIDTH - LOGLINE;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_DM = 2'd1,
    S_BUSY_PF = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [WIDTH-1:0]   mem_q [QDEPTH];

  logic               fifo_empty;
  logic               fifo_full;
  logic [PTR_W-1:0]   fifo_count;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [WIDTH-1:0]   head_addr;
  logic [LINE_W-1:0]  pf_line;
  logic               stage_free;
  logic               pf_allowed;
  logic               pop;
  logic               stale;
  logic               dup_fifo;
  logic               dup;
  logic               push;
  logic               push_drop;

  // FIFO status from the wrap-bit pointers
  assign rd_idx     = rd_q[IDX_W-1:0];
  assign wr_idx     = wr_q[IDX_W-1:0];
  assign fifo_count = PTR_W'(wr_q - rd_q);
  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[IDX_W] != rd_q[IDX_W]) && (wr_idx == rd_idx);
  assign head_addr  = mem_q[rd_idx];
  assign pf_line    = pf_address_i[WIDTH-1:LOGLINE];

  // The output stage can take a new request when empty or handing off now
  assign stage_free = (state_q == S_IDLE) || ((state_q != S_IDLE) && lo_ready_i);

  // Prefetch pop: stage free, no demand this cycle, MSHRs below threshold
  assign pf_allowed = !fifo_empty
                   && (mshr_occupancy_i < MSHR_W'(MSHR_THRESHOLD))
                   && !flush_i;
  assign pop        = stage_free && !dm_valid_i && pf_allowed;

  // Head that has waited MAX_AGE cycles and is not leaving now is discarded;
  // a flush already removes it, so it is not counted twice
  assign stale = !fifo_empty && !flush_i && !pop && (age_q == AGE_W'(MAX_AGE));

  // Duplicate line against every occupied slot (start-of-cycle contents)
  always_comb begin
    dup_fifo = 1'b0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (({1'b0, IDX_W'(IDX_W'(i) - rd_idx)} < fifo_count) &&
          (mem_q[i][WIDTH-1:LOGLINE] == pf_line)) begin
        dup_fifo = 1'b1;
      end
    end
  end

  assign dup = dup_fifo
            || ((state_q == S_BUSY_PF) && (addr_q[WIDTH-1:LOGLINE] == pf_line))
            || (dm_valid_i && (dm_address_i[WIDTH-1:LOGLINE] == pf_line));

  // Push classification: flush discards silently, dup/full drop with count
  assign push_drop = pf_valid_i && !flush_i && (dup || fifo_full);
  assign push      = pf_valid_i && !flush_i && !dup && !fifo_full;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: reload only when the stage is free, demand first
  always_comb begin
    state_d = state_q;
    if (stage_free) begin
      if (dm_valid_i) begin
        state_d = S_BUSY_DM;
      end else if (pop) begin
        state_d = S_BUSY_PF;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    lo_valid_o       = 1'b0;
    lo_is_prefetch_o = 1'b0;
    case (state_q)
      S_BUSY_DM: begin
        lo_valid_o       = 1'b1;
        lo_is_prefetch_o = 1'b0;
      end
      S_BUSY_PF: begin
        lo_valid_o       = 1'b1;
        lo_is_prefetch_o = 1'b1;
      end
      default: begin
        lo_valid_o       = 1'b0;
        lo_is_prefetch_o = 1'b0;
      end
    endcase
  end

  // Request address, FIFO pointers, head age and drop counter next values
  always_comb begin
    addr_d = addr_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    age_d  = age_q;
    drop_d = drop_q;

    if (stage_free && dm_valid_i) begin
      addr_d = dm_address_i;
    end else if (pop) begin
      addr_d = head_addr;
    end

    if (push) begin
      wr_d = PTR_W'(wr_q + PTR_W'(1));
    end
    if (pop || stale) begin
      rd_d = PTR_W'(rd_q + PTR_W'(1));
    end
    // Flush never coincides with push or pop, so catching up rd empties it
    if (flush_i) begin
      rd_d = wr_q;
    end

    // Age restarts whenever the head changes or there is no head
    if (fifo_empty || pop || stale || flush_i) begin
      age_d = '0;
    end else begin
      age_d = AGE_W'(age_q + AGE_W'(1));
    end

    // One increment per cycle even if a push-drop and a stale discard coincide
    if ((push_drop || stale) && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = CNT_W'(drop_q + CNT_W'(1));
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      age_q  <= '0;
      drop_q <= '0;
    end else begin
      addr_q <= addr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      age_q  <= age_d;
      drop_q <= drop_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx] <= pf_address_i;
    end
  end

  assign dm_ready_o   = stage_free;
  assign pf_ready_o   = !fifo_full;
  assign lo_address_o = addr_q;
  assign drop_count_o = drop_q;

endmodule
